// File: rtl/aggr_pipe_ctrl.sv
// aggr_pipe_ctrl: sequences one image frame through a stall-able delay
// pipeline of PIPE_DEPTH words. It accepts pixels under valid/ready and
// drives the pipeline enable. At each row end it injects PIPE_DEPTH filler
// beats so the row's last words drain. Each output beat is tagged with
// real/start-of-row/end-of-row/end-of-frame flags.
// Optional feature: define AGGR_CTRL_STATS_EN to build the stall counter.
module aggr_pipe_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIPE_DEPTH = 4,
   localparam int CW = $clog2(IMG_WIDTH),
   // a single-row frame still needs a 1-bit row port
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          pipe_en,
   output logic          pipe_fill,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_sol,
   output logic          out_eol,
   output logic          out_eof,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          busy,
   output logic          frame_done,
   output logic [31:0]   stall_cnt
);

   localparam int FW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(PIPE_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [CW-1:0]                r_col;
   logic [RW-1:0]                r_row;
   logic [FW-1:0]                r_fill_cnt;
   // tag bits: [3]=real [2]=sol [1]=eol [0]=eof
   logic [PIPE_DEPTH-1:0][3:0]   r_tag;
   logic [3:0]                   w_head;
   logic [3:0]                   w_tag_in;
   logic                         w_space;

   assign w_head    = r_tag[PIPE_DEPTH-1];
   assign w_space   = ~w_head[3] | out_ready;
   assign w_tag_in  = {~pipe_fill, (r_col == '0), (r_col == COL_LAST),
                       (r_row == ROW_LAST) && (r_col == COL_LAST)};
   assign out_valid = pipe_en & w_head[3];
   assign out_sol   = out_valid & w_head[2];
   assign out_eol   = out_valid & w_head[1];
   assign out_eof   = out_valid & w_head[0];
   assign col       = r_col;
   assign row       = r_row;
   assign busy      = (r_state != S_IDLE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state and handshake/enable decode
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      pipe_en     = 1'b0;
      pipe_fill   = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            in_ready = w_space;
            pipe_en  = in_valid & w_space;
            if (in_valid && w_space && (r_col == COL_LAST)) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            pipe_fill = 1'b1;
            pipe_en   = w_space;
            if (w_space && (r_fill_cnt == FILL_LAST))
               w_state_nxt = (r_row == ROW_LAST) ? S_DONE : S_RUN;
         end
         S_DONE: begin
            frame_done  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // column, row and filler-beat counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_fill_cnt <= '0;
      end else if (pipe_en) begin
         if (r_state == S_RUN) begin
            if (r_col == COL_LAST) begin
               r_col      <= '0;
               r_fill_cnt <= '0;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end else if (r_state == S_FLUSH) begin
            if (r_fill_cnt == FILL_LAST) begin
               r_fill_cnt <= '0;
               r_row      <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_fill_cnt <= r_fill_cnt + 1'b1;
            end
         end
      end
   end

   // tag shift register, advancing in lockstep with the pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag <= '0;
      end else if (pipe_en) begin
         r_tag[0] <= w_tag_in;
         for (int unsigned i = 1; i < PIPE_DEPTH; i++) r_tag[i] <= r_tag[i-1];
      end
   end

`ifdef AGGR_CTRL_STATS_EN
   logic [31:0] r_stall_cnt;

   // saturating count of RUN/FLUSH cycles without a pipeline advance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_stall_cnt <= '0;
      end else if (((r_state == S_RUN) || (r_state == S_FLUSH)) && !pipe_en &&
                   (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_aggr_pipe_ctrl.sv
// Self-checking bench for aggr_pipe_ctrl. The main instance (W=4,H=2,D=4)
// is checked every cycle against a frame-level model built from advance
// numbers: a word entering on advance k must be strobed on advance k+D.
// A second instance (W=2,H=1,D=1) gets a short directed check.
module tb_aggr_pipe_ctrl;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int D  = 4;
   localparam int W2 = 2;
   localparam int H2 = 1;
   localparam int D2 = 1;
   localparam int LIMIT = 2000;
`ifdef AGGR_CTRL_STATS_EN
   localparam int STALL_EXP = 10;
`else
   localparam int STALL_EXP = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, in_valid, out_ready;
   logic        in_ready, pipe_en, pipe_fill, out_valid;
   logic        out_sol, out_eol, out_eof, busy, frame_done;
   logic [1:0]  col;
   logic [0:0]  row;
   logic [31:0] stall_cnt;

   logic        start_s, in_valid_s, out_ready_s;
   logic        in_ready_s, pipe_en_s, pipe_fill_s, out_valid_s;
   logic        sol_s, eol_s, eof_s, busy_s, frame_done_s;
   logic [0:0]  col_s;
   logic [0:0]  row_s;
   logic [31:0] stall_cnt_s;

   aggr_pipe_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_DEPTH(D)) u_dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .pipe_en(pipe_en), .pipe_fill(pipe_fill),
      .out_valid(out_valid), .out_ready(out_ready), .out_sol(out_sol),
      .out_eol(out_eol), .out_eof(out_eof), .col(col), .row(row),
      .busy(busy), .frame_done(frame_done), .stall_cnt(stall_cnt));

   aggr_pipe_ctrl #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2), .PIPE_DEPTH(D2)) u_dut_s (
      .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s),
      .in_ready(in_ready_s), .pipe_en(pipe_en_s), .pipe_fill(pipe_fill_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s), .out_sol(sol_s),
      .out_eol(eol_s), .out_eof(eof_s), .col(col_s), .row(row_s),
      .busy(busy_s), .frame_done(frame_done_s), .stall_cnt(stall_cnt_s));

   int n_err = 0;
   int n_chk = 0;

   // reference model state
   int m_phase;        // 0 idle, 1 frame active, 2 done cycle
   int m_acc;          // words accepted in this frame
   int m_fill_left;    // filler beats still owed for the current row
   int m_adv;          // advances completed
   int m_str;          // words strobed out in this frame
   int m_stall;
   int q_k[$];         // advance number on which each in-flight word entered

   int obs_acc, obs_str, obs_fill, obs_done, done_cyc, cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit head_real();
      return (q_k.size() > 0) && (q_k[0] + D == m_adv + 1);
   endfunction

   task automatic cycle(input logic s, input logic iv, input logic ordy, input logic r);
      logic act, fl, hr, sp, e_en, e_rdy, e_ov, e_sol, e_eol, e_eof;
      int   e_col, e_row, e_stall;
      @(negedge clk);
      start = s; in_valid = iv; out_ready = ordy; rst = r;
      #1;
      act   = (m_phase == 1);
      fl    = act && (m_fill_left > 0);
      hr    = head_real();
      sp    = !hr || ordy;
      e_en  = act && (fl ? sp : (iv && sp));
      e_rdy = act && !fl && sp;
      e_ov  = e_en && hr;
      e_sol = e_ov && (m_str % W == 0);
      e_eol = e_ov && (m_str % W == W - 1);
      e_eof = e_ov && (m_str == W * H - 1);
      e_col = m_acc % W;
      e_row = fl ? ((m_acc - 1) / W) % H : (m_acc / W) % H;
      e_stall = (STALL_EXP != 0) ? m_stall : 0;
      chk("in_ready",   32'(in_ready),   32'(e_rdy));
      chk("pipe_en",    32'(pipe_en),    32'(e_en));
      chk("pipe_fill",  32'(pipe_fill),  32'(fl));
      chk("out_valid",  32'(out_valid),  32'(e_ov));
      chk("out_sol",    32'(out_sol),    32'(e_sol));
      chk("out_eol",    32'(out_eol),    32'(e_eol));
      chk("out_eof",    32'(out_eof),    32'(e_eof));
      chk("col",        32'(col),        32'(e_col));
      chk("row",        32'(row),        32'(e_row));
      chk("busy",       32'(busy),       32'(m_phase != 0));
      chk("frame_done", 32'(frame_done), 32'(m_phase == 2));
      chk("stall_cnt",  stall_cnt,       32'(e_stall));
      if (in_valid && in_ready) obs_acc++;
      if (out_valid) obs_str++;
      if (pipe_en && pipe_fill) obs_fill++;
      if (frame_done) begin obs_done++; done_cyc = cyc; end
      if (r) begin
         m_phase = 0; m_acc = 0; m_fill_left = 0; m_str = 0; m_stall = 0;
         q_k.delete();
      end else begin
         case (m_phase)
            0: if (s) begin
                  m_phase = 1; m_acc = 0; m_fill_left = 0; m_str = 0; m_stall = 0;
                  q_k.delete();
               end
            1: begin
                  if (!e_en) m_stall++;
                  else begin
                     m_adv++;
                     if (e_ov) begin void'(q_k.pop_front()); m_str++; end
                     if (fl) begin
                        m_fill_left--;
                        if (m_fill_left == 0 && m_acc == W * H) m_phase = 2;
                     end else begin
                        q_k.push_back(m_adv);
                        m_acc++;
                        if (m_acc % W == 0) m_fill_left = D;
                     end
                  end
               end
            default: m_phase = 0;
         endcase
      end
      @(posedge clk);
      cyc++;
   endtask

   // mode: 0 full rate, 1 toggling in_valid, 2 random, 3 random + stray
   // start pulses, 4 full rate with a 10-cycle downstream stall
   int last_start;
   task automatic do_frame(input int mode);
      int   n;
      bit   stalled;
      logic iv, ordy, sp;
      n = 0; stalled = 1'b0;
      last_start = cyc;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      while (m_phase != 0 && n < LIMIT) begin
         iv = 1'b1; ordy = 1'b1; sp = 1'b0;
         case (mode)
            1: iv = (n % 2 == 0);
            2: begin
                  iv = 1'($urandom_range(0, 1));
                  ordy = ($urandom_range(0, 3) != 0);
               end
            3: begin
                  iv = 1'($urandom_range(0, 1));
                  ordy = ($urandom_range(0, 3) != 0);
                  sp = ($urandom_range(0, 4) == 0);
               end
            4: if (!stalled && head_real()) begin
                  stalled = 1'b1;
                  repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b0);
                  #2;
                  chk("stall_cnt_after_stall", stall_cnt, 32'(STALL_EXP));
               end
            default: ;
         endcase
         cycle(sp, iv, ordy, 1'b0);
         n++;
      end
      chk("frame_terminates", 32'(n < LIMIT), 32'd1);
   endtask

   int a0, s0, f0, d0, k;
   int sa[$], ss[$];
   logic [2:0] flg[$];
   int sf, sdone;

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      start_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b0;
      m_phase = 0; m_acc = 0; m_fill_left = 0; m_adv = 0; m_str = 0; m_stall = 0;
      obs_acc = 0; obs_str = 0; obs_fill = 0; obs_done = 0; done_cyc = -1; cyc = 0;
      repeat (2) @(posedge clk);
      // reset values
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // full-throughput frame
      a0 = obs_acc; s0 = obs_str; f0 = obs_fill;
      do_frame(0);
      chk("t1_accepts", 32'(obs_acc - a0), 32'(W * H));
      chk("t1_strobes", 32'(obs_str - s0), 32'(W * H));
      chk("t1_fills",   32'(obs_fill - f0), 32'(D * H));
      chk("t1_done_latency", 32'(done_cyc - last_start), 32'(H * (W + D) + 1));

      // downstream stall of 10 cycles
      do_frame(4);
      // toggling in_valid
      do_frame(1);
      // stray start pulses mid-frame
      d0 = obs_done;
      do_frame(3);
      chk("t4_one_frame_done", 32'(obs_done - d0), 32'd1);

      // reset during row-0 flush, then a clean frame
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      k = 0;
      while (m_fill_left == 0 && k < 20) begin cycle(1'b0, 1'b1, 1'b1, 1'b0); k++; end
      chk("t5_reached_flush", 32'(m_fill_left > 0), 32'd1);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      #2;
      chk("t5_busy",      32'(busy),      32'd0);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_col",       32'(col),       32'd0);
      chk("t5_row",       32'(row),       32'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      a0 = obs_str;
      do_frame(0);
      chk("t5_clean_strobes", 32'(obs_str - a0), 32'(W * H));

      // random traffic
      repeat (3) do_frame(2);

      // D=1, W=2, H=1 instance
      sf = 0; sdone = -1;
      @(negedge clk);
      start_s = 1'b1; in_valid_s = 1'b1; out_ready_s = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start_s = 1'b0;
         #1;
         if (in_valid_s && in_ready_s) sa.push_back(c);
         if (out_valid_s) begin
            ss.push_back(c);
            flg.push_back({sol_s, eol_s, eof_s});
         end
         if (pipe_en_s && pipe_fill_s) sf++;
         if (frame_done_s) sdone = c;
      end
      chk("s_accepts", 32'(sa.size()), 32'(W2 * H2));
      chk("s_strobes", 32'(ss.size()), 32'(W2 * H2));
      if (sa.size() == 2 && ss.size() == 2) begin
         chk("s_latency0", 32'(ss[0] - sa[0]), 32'(D2));
         chk("s_latency1", 32'(ss[1] - sa[1]), 32'(D2));
         chk("s_flags0", 32'(flg[0]), 32'b100);
         chk("s_flags1", 32'(flg[1]), 32'b011);
      end
      chk("s_fills", 32'(sf), 32'(D2 * H2));
      chk("s_done_cycle", 32'(sdone), 32'(H2 * (W2 + D2) + 1));
      chk("s_busy_end", 32'(busy_s), 32'd0);
      chk("s_stall_cnt", stall_cnt_s, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
